// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: immediate-in stream and extended-result-out stream.
// The DUT takes the slave modport; the upstream/downstream side takes master.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_illegal;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_illegal
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender (zero/sign/branch/upper) followed by a 2-entry result FIFO.
// Define IMM_EXTEND_UPPER_EN to build the upper (LUI) mode; otherwise mode 11 zero-extends and is flagged illegal.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  imm_extend_pipe_if.slave   bus
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] acc_data;
  logic             acc_illegal;

  logic [OUT_W-1:0] mem_data [2];
  logic             mem_illegal [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             accept;
  logic             deliver;

  assign zext = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
  assign sext = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};

  // The result is formed at acceptance so the FIFO stores finished values only.
  always_comb begin
    acc_data    = zext;
    acc_illegal = 1'b0;
    case (bus.in_mode)
      2'b00: acc_data = zext;
      2'b01: acc_data = sext;
      2'b10: acc_data = sext << 2;
      default: begin
`ifdef IMM_EXTEND_UPPER_EN
        acc_data = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
`else
        acc_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign bus.in_ready    = (count != 2'd2);
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_data    = mem_data[rd_ptr];
  assign bus.out_illegal = mem_illegal[rd_ptr];

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i]    <= '0;
        mem_illegal[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        mem_data[wr_ptr]    <= acc_data;
        mem_illegal[wr_ptr] <= acc_illegal;
        wr_ptr              <= ~wr_ptr;
      end
      if (deliver) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept && !deliver) begin
        count <= count + 2'd1;
      end else if (!accept && deliver) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus a randomized run
// against a queue-based reference model. Honours IMM_EXTEND_UPPER_EN like the design.
module tb_imm_extend_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v, input logic [15:0] imm,
                                input logic [1:0] mode, input logic ord);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = mode;
    bus.out_ready = ord;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference extension computed with plain integer arithmetic.
  function automatic void ref_model(input logic [15:0] imm, input logic [1:0] mode,
                                    output logic [31:0] data, output logic ill);
    int s;
    s    = int'($signed(imm));
    ill  = 1'b0;
    data = 32'(imm);
    case (mode)
      2'd0: data = 32'(imm);
      2'd1: data = 32'(s);
      2'd2: data = 32'(s * 4);
      default: begin
`ifdef IMM_EXTEND_UPPER_EN
        data = 32'(imm) * 32'd65536;
`else
        data = 32'(imm);
        ill  = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    apply_stimulus(1'b1, 16'h1234, 2'b01, 1'b0);
    repeat (2) next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid actual=%0b expected=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready actual=%0b expected=1", bus.in_ready); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_data actual=%h expected=00000000", bus.out_data); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_illegal actual=%0b expected=0", bus.out_illegal); end
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0);
    reset = 1'b0;
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_empty actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_sign_extend;
    apply_stimulus(1'b1, 16'h8000, 2'b01, 1'b1);
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL sext_valid actual=%0b expected=1", bus.out_valid); end
    total++; if (bus.out_data !== 32'hFFFF8000) begin bad++; $display("[TB] FAIL sext_data actual=%h expected=ffff8000", bus.out_data); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL sext_illegal actual=%0b expected=0", bus.out_illegal); end
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sext_drained actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    apply_stimulus(1'b1, 16'h8000, 2'b00, 1'b1);
    next_cycle;
    apply_stimulus(1'b1, 16'hFFFF, 2'b10, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00008000) begin bad++; $display("[TB] FAIL b2b_first actual=%0b/%h expected=1/00008000", bus.out_valid, bus.out_data); end
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFFFFC) begin bad++; $display("[TB] FAIL b2b_second actual=%0b/%h expected=1/fffffffc", bus.out_valid, bus.out_data); end
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_upper;
    logic [31:0] exp_data;
    logic        exp_ill;
`ifdef IMM_EXTEND_UPPER_EN
    exp_data = 32'h12340000;
    exp_ill  = 1'b0;
`else
    exp_data = 32'h00001234;
    exp_ill  = 1'b1;
`endif
    apply_stimulus(1'b1, 16'h1234, 2'b11, 1'b1);
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    total++; if (bus.out_data !== exp_data) begin bad++; $display("[TB] FAIL upper_data actual=%h expected=%h", bus.out_data, exp_data); end
    total++; if (bus.out_illegal !== exp_ill) begin bad++; $display("[TB] FAIL upper_illegal actual=%0b expected=%0b", bus.out_illegal, exp_ill); end
    next_cycle;
  endtask

  task automatic test_backpressure;
    apply_stimulus(1'b1, 16'h0001, 2'b00, 1'b0);
    next_cycle;
    apply_stimulus(1'b1, 16'h0002, 2'b00, 1'b0);
    next_cycle;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready actual=%0b expected=0", bus.in_ready); end
    apply_stimulus(1'b1, 16'h0003, 2'b00, 1'b0);
    next_cycle;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_still_full actual=%0b expected=0", bus.in_ready); end
    total++; if (bus.out_data !== 32'h1) begin bad++; $display("[TB] FAIL bp_head_stable actual=%h expected=00000001", bus.out_data); end
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    next_cycle;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h2) begin bad++; $display("[TB] FAIL bp_second actual=%0b/%h expected=1/00000002", bus.out_valid, bus.out_data); end
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_third actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_simultaneous;
    apply_stimulus(1'b1, 16'h0011, 2'b00, 1'b0);
    next_cycle;
    apply_stimulus(1'b1, 16'h0022, 2'b00, 1'b1);
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0);
    total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_count actual=%0b/%0b expected=1/1", bus.out_valid, bus.in_ready); end
    total++; if (bus.out_data !== 32'h22) begin bad++; $display("[TB] FAIL simul_head actual=%h expected=00000022", bus.out_data); end
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL simul_single actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid;
    apply_stimulus(1'b1, 16'h000A, 2'b00, 1'b0);
    next_cycle;
    apply_stimulus(1'b1, 16'h000B, 2'b00, 1'b0);
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_full actual=%0b expected=0", bus.in_ready); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_immediate actual=%0b/%0b expected=0/1", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, 16'h000C, 2'b01, 1'b1);
    next_cycle;
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000000C) begin bad++; $display("[TB] FAIL midrst_first actual=%0b/%h expected=1/0000000c", bus.out_valid, bus.out_data); end
    next_cycle;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_drained actual=%0b expected=0", bus.out_valid); end
  endtask

  task automatic test_random;
    logic [32:0] exp_q[$];
    logic [31:0] d;
    logic        il;
    logic        v;
    logic        ord;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        acc;
    logic        del;
    for (int i = 0; i < 400; i++) begin
      total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++; $display("[TB] FAIL rand_valid cyc=%0d actual=%0b expected=%0b", i, bus.out_valid, exp_q.size() != 0); end
      total++; if (bus.in_ready !== (exp_q.size() != 2)) begin bad++; $display("[TB] FAIL rand_ready cyc=%0d actual=%0b expected=%0b", i, bus.in_ready, exp_q.size() != 2); end
      if (exp_q.size() != 0) begin
        total++; if (bus.out_data !== exp_q[0][31:0]) begin bad++; $display("[TB] FAIL rand_data cyc=%0d actual=%h expected=%h", i, bus.out_data, exp_q[0][31:0]); end
        total++; if (bus.out_illegal !== exp_q[0][32]) begin bad++; $display("[TB] FAIL rand_illegal cyc=%0d actual=%0b expected=%0b", i, bus.out_illegal, exp_q[0][32]); end
      end
      v    = ($urandom_range(0, 3) != 0);
      ord  = ($urandom_range(0, 1) != 0);
      imm  = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      if (i >= 390) begin
        v   = 1'b0;
        ord = 1'b1;
      end
      apply_stimulus(v, imm, mode, ord);
      acc = v && (exp_q.size() < 2);
      del = ord && (exp_q.size() > 0);
      ref_model(imm, mode, d, il);
      @(posedge clk);
      if (del) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({il, d});
      @(negedge clk);
    end
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0);
  endtask

  initial begin
    apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_sign_extend();
    test_back_to_back();
    test_upper();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
